// File: rtl/uart_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Purpose  : Assembles FRAME_BYTES payload bytes and a terminator byte from
//            the uart_rx byte stream into one frame. It applies an inter-byte
//            timeout, resynchronises on the terminator after a framing error,
//            and presents only complete, good frames downstream. The last
//            good frame is held until the next one is accepted.
// Ports    : clk            - system clock
//            reset_uart     - synchronous active-high reset
//            i_rx_valid     - one-cycle strobe, i_rx_data valid
//            i_rx_data      - received byte
//            i_rx_break     - line break, aborts any frame in progress
//            o_frame_data   - last good frame, first byte in the MSBs
//            o_frame_valid  - one-cycle pulse when o_frame_data updates
//            o_err_term     - pulse: terminator slot held a wrong byte
//            o_err_timeout  - pulse: inter-byte timeout inside a frame
//            o_err_chk      - pulse: checksum mismatch (checksum build only)
//            o_frame_count  - good frame count, wraps 255 -> 0
//            o_busy         - high whenever a frame or resync is in progress
// Options  : UART_FRAME_RX_CHECKSUM_EN - adds an XOR checksum byte between
//            the payload and the terminator.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
    parameter int PAYLOAD_BITS   = 8,
    parameter int FRAME_BYTES    = 3,
    parameter int TERMINATOR     = 'h0A,
    parameter int TIMEOUT_CYCLES = 270_270
) (
    input  logic                                clk,
    input  logic                                reset_uart,
    input  logic                                i_rx_valid,
    input  logic [PAYLOAD_BITS-1:0]             i_rx_data,
    input  logic                                i_rx_break,
    output logic [FRAME_BYTES*PAYLOAD_BITS-1:0] o_frame_data,
    output logic                                o_frame_valid,
    output logic                                o_err_term,
    output logic                                o_err_timeout,
    output logic                                o_err_chk,
    output logic [7:0]                          o_frame_count,
    output logic                                o_busy
);

    localparam int c_FRAME_W = FRAME_BYTES * PAYLOAD_BITS;
    localparam int c_IDX_W   = 4;
    localparam int c_TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PAYLOAD_BITS-1:0] c_TERM     = PAYLOAD_BITS'(TERMINATOR);
    localparam logic [c_TMO_W-1:0]      c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]      c_LAST_IDX = c_IDX_W'(FRAME_BYTES - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd1;
    localparam logic [2:0] c_ST_TERM    = 3'd3;
    localparam logic [2:0] c_ST_RESYNC  = 3'd4;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHECK         = 3'd2;
    localparam logic [2:0] c_ST_AFTER_PAYLOAD = c_ST_CHECK;
`else
    localparam logic [2:0] c_ST_AFTER_PAYLOAD = c_ST_TERM;
`endif

    logic [2:0]              r_state_q,       w_state_d;
    logic [c_FRAME_W-1:0]    r_staging_q,     w_staging_d;
    logic [c_IDX_W-1:0]      r_idx_q,         w_idx_d;
    logic [c_TMO_W-1:0]      r_tmo_q,         w_tmo_d;
    logic [c_FRAME_W-1:0]    r_frame_data_q,  w_frame_data_d;
    logic                    r_frame_valid_q, w_frame_valid_d;
    logic                    r_err_term_q,    w_err_term_d;
    logic                    r_err_tmo_q,     w_err_tmo_d;
    logic [7:0]              r_count_q,       w_count_d;
    logic                    w_in_frame;
    logic                    w_expire;

`ifdef UART_FRAME_RX_CHECKSUM_EN
    logic                    r_err_chk_q,     w_err_chk_d;
    logic [PAYLOAD_BITS-1:0] w_xor;

    always_comb begin
        w_xor = '0;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            w_xor = w_xor ^ r_staging_q[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end
`endif

    // The timeout only guards the gap between bytes of a frame in progress;
    // idle line time and resync hunting are unbounded.
    always_comb begin
        w_in_frame = (r_state_q == c_ST_PAYLOAD) || (r_state_q == c_ST_TERM);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        if (r_state_q == c_ST_CHECK) begin
            w_in_frame = 1'b1;
        end
`endif
    end

    // A strobe in the expiry cycle wins, so expiry needs an absent strobe.
    assign w_expire = w_in_frame && !i_rx_valid && (r_tmo_q == c_TMO_LAST);

    always_comb begin
        w_state_d       = r_state_q;
        w_staging_d     = r_staging_q;
        w_idx_d         = r_idx_q;
        w_frame_data_d  = r_frame_data_q;
        w_count_d       = r_count_q;
        w_frame_valid_d = 1'b0;
        w_err_term_d    = 1'b0;
        w_err_tmo_d     = 1'b0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
        w_err_chk_d     = 1'b0;
`endif
        w_tmo_d = (w_in_frame && !i_rx_valid) ? (r_tmo_q + c_TMO_W'(1)) : '0;

        if ((r_state_q != c_ST_IDLE) && i_rx_break) begin
            // Break aborts silently and beats a simultaneous strobe.
            w_state_d   = c_ST_IDLE;
            w_staging_d = '0;
            w_idx_d     = '0;
            w_tmo_d     = '0;
        end else begin
            case (r_state_q)
                c_ST_IDLE: begin
                    if (i_rx_valid) begin
                        w_staging_d[c_FRAME_W-1 -: PAYLOAD_BITS] = i_rx_data;
                        w_idx_d   = c_IDX_W'(1);
                        w_state_d = (FRAME_BYTES == 1) ? c_ST_AFTER_PAYLOAD : c_ST_PAYLOAD;
                    end
                end
                c_ST_PAYLOAD: begin
                    if (i_rx_valid) begin
                        // Byte k lands in slot k counted down from the MSBs.
                        for (int i = 0; i < FRAME_BYTES; i++) begin
                            if (r_idx_q == c_IDX_W'(i)) begin
                                w_staging_d[(FRAME_BYTES-1-i)*PAYLOAD_BITS +: PAYLOAD_BITS] = i_rx_data;
                            end
                        end
                        w_idx_d = r_idx_q + c_IDX_W'(1);
                        if (r_idx_q == c_LAST_IDX) begin
                            w_state_d = c_ST_AFTER_PAYLOAD;
                        end
                    end
                end
`ifdef UART_FRAME_RX_CHECKSUM_EN
                c_ST_CHECK: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == w_xor) begin
                            w_state_d = c_ST_TERM;
                        end else begin
                            w_err_chk_d = 1'b1;
                            w_state_d   = c_ST_RESYNC;
                            w_staging_d = '0;
                            w_idx_d     = '0;
                        end
                    end
                end
`endif
                c_ST_TERM: begin
                    if (i_rx_valid) begin
                        w_idx_d = '0;
                        if (i_rx_data == c_TERM) begin
                            w_frame_data_d  = r_staging_q;
                            w_frame_valid_d = 1'b1;
                            w_count_d       = r_count_q + 8'd1;
                            w_state_d       = c_ST_IDLE;
                        end else begin
                            w_err_term_d = 1'b1;
                            w_state_d    = c_ST_RESYNC;
                            w_staging_d  = '0;
                        end
                    end
                end
                c_ST_RESYNC: begin
                    if (i_rx_valid && (i_rx_data == c_TERM)) begin
                        w_state_d = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = c_ST_IDLE;
                end
            endcase

            if (w_expire) begin
                w_err_tmo_d = 1'b1;
                w_state_d   = c_ST_IDLE;
                w_staging_d = '0;
                w_idx_d     = '0;
                w_tmo_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            r_state_q       <= c_ST_IDLE;
            r_staging_q     <= '0;
            r_idx_q         <= '0;
            r_tmo_q         <= '0;
            r_frame_data_q  <= '0;
            r_frame_valid_q <= 1'b0;
            r_err_term_q    <= 1'b0;
            r_err_tmo_q     <= 1'b0;
            r_count_q       <= 8'd0;
        end else begin
            r_state_q       <= w_state_d;
            r_staging_q     <= w_staging_d;
            r_idx_q         <= w_idx_d;
            r_tmo_q         <= w_tmo_d;
            r_frame_data_q  <= w_frame_data_d;
            r_frame_valid_q <= w_frame_valid_d;
            r_err_term_q    <= w_err_term_d;
            r_err_tmo_q     <= w_err_tmo_d;
            r_count_q       <= w_count_d;
        end
    end

`ifdef UART_FRAME_RX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset_uart) begin
            r_err_chk_q <= 1'b0;
        end else begin
            r_err_chk_q <= w_err_chk_d;
        end
    end
    assign o_err_chk = r_err_chk_q;
`else
    assign o_err_chk = 1'b0;
`endif

    assign o_frame_data  = r_frame_data_q;
    assign o_frame_valid = r_frame_valid_q;
    assign o_err_term    = r_err_term_q;
    assign o_err_timeout = r_err_tmo_q;
    assign o_frame_count = r_count_q;
    assign o_busy        = (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Purpose  : Self-checking bench for uart_frame_rx. A queue-based frame model
//            predicts every output each cycle; directed sequences add literal
//            expectations, followed by a randomized frame stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

    localparam int         FB   = 3;
    localparam int         TMO  = 50;
    localparam logic [7:0] TERM = 8'h0A;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int FLEN = FB + 1 + CK;

    logic        clk = 1'b0;
    logic        reset_uart = 1'b1;
    logic        v = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        brk = 1'b0;
    wire  [23:0] o_frame_data;
    wire         o_frame_valid, o_err_term, o_err_timeout, o_err_chk, o_busy;
    wire  [7:0]  o_frame_count;

    uart_frame_rx #(
        .PAYLOAD_BITS   (8),
        .FRAME_BYTES    (FB),
        .TERMINATOR     (TERM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_uart    (reset_uart),
        .i_rx_valid    (v),
        .i_rx_data     (d),
        .i_rx_break    (brk),
        .o_frame_data  (o_frame_data),
        .o_frame_valid (o_frame_valid),
        .o_err_term    (o_err_term),
        .o_err_timeout (o_err_timeout),
        .o_err_chk     (o_err_chk),
        .o_frame_count (o_frame_count),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame in progress is just the list of bytes taken so far; its length
    // says which slot the next byte fills.
    logic [7:0]  m_buf[$];
    bit          m_resync = 0;
    int          m_idle   = 0;
    logic [23:0] e_data   = '0;
    logic [7:0]  e_cnt    = '0;
    bit          e_fv = 0, e_et = 0, e_eto = 0, e_ec = 0;
    bit          cmp_en = 0;

    function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        return x;
    endfunction

    always @(posedge clk) begin
        e_fv = 0; e_et = 0; e_eto = 0; e_ec = 0;
        if (reset_uart) begin
            m_buf.delete(); m_resync = 0; m_idle = 0; e_data = '0; e_cnt = '0;
        end else if ((m_resync || m_buf.size() != 0) && brk) begin
            m_buf.delete(); m_resync = 0; m_idle = 0;
        end else if (m_resync) begin
            if (v && d == TERM) m_resync = 0;
        end else if (m_buf.size() == 0) begin
            if (v) begin m_buf.push_back(d); m_idle = 0; end
        end else if (v) begin
            m_idle = 0;
            if (m_buf.size() == FLEN - 1) begin
                if (d == TERM) begin
                    e_data = '0;
                    for (int i = 0; i < FB; i++) e_data = {e_data[15:0], m_buf[i]};
                    e_fv = 1; e_cnt = e_cnt + 8'd1;
                end else begin
                    e_et = 1; m_resync = 1;
                end
                m_buf.delete();
            end else if (CK == 1 && m_buf.size() == FB) begin
                if (d == xor_of(m_buf)) m_buf.push_back(d);
                else begin e_ec = 1; m_buf.delete(); m_resync = 1; end
            end else begin
                m_buf.push_back(d);
            end
        end else if (m_idle == TMO - 1) begin
            e_eto = 1; m_buf.delete(); m_idle = 0;
        end else begin
            m_idle++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("frame_data",  o_frame_data,  e_data);
            chk("frame_valid", o_frame_valid, e_fv);
            chk("err_term",    o_err_term,    e_et);
            chk("err_timeout", o_err_timeout, e_eto);
            chk("err_chk",     o_err_chk,     e_ec);
            chk("frame_count", o_frame_count, e_cnt);
            chk("busy",        o_busy,        (m_resync || m_buf.size() != 0));
        end
    end

    // ---------------- stimulus helpers (start/end at posedge+2) ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        v = 1'b1; d = b; step(); v = 1'b0;
        repeat (gap) step();
    endtask

    // Payload (+checksum) with gap after each, terminator with no gap so the
    // caller can see the result pulse immediately.
    task automatic send_frame(input logic [23:0] p, input logic [7:0] t, input int gap);
        for (int i = 0; i < FB; i++) send(p[23-8*i -: 8], gap);
        if (CK == 1) send(p[23:16] ^ p[15:8] ^ p[7:0], gap);
        send(t, 0);
    endtask

    task automatic do_reset();
        reset_uart = 1'b1; step(); reset_uart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [23:0] p;
        logic [7:0]  wb[$];

        reset_uart = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_uart = 1'b0;
        cmp_en = 1;
        chk("reset_data",  o_frame_data,  24'h0);
        chk("reset_count", o_frame_count, 8'd0);
        chk("reset_busy",  o_busy,        1'b0);

        // Good frame
        send_frame(24'h123456, TERM, 1);
        chk("good_valid", o_frame_valid, 1'b1);
        chk("good_data",  o_frame_data,  24'h123456);
        chk("good_count", o_frame_count, 8'd1);
        step();
        chk("good_valid_once", o_frame_valid, 1'b0);
        chk("good_busy_after", o_busy,        1'b0);

        // Bad terminator, resync, then good frame
        send_frame(24'hAABBCC, 8'h55, 1);
        chk("badterm_pulse", o_err_term,   1'b1);
        chk("badterm_hold",  o_frame_data, 24'h123456);
        send(8'h01, 1);
        send(TERM, 1);
        chk("resync_done",   o_busy,       1'b0);
        chk("resync_hold",   o_frame_data, 24'h123456);
        send_frame(24'h010203, TERM, 1);
        chk("after_resync_data",  o_frame_data,  24'h010203);
        chk("after_resync_count", o_frame_count, 8'd2);

        // Timeout: count value 49 is the last idle cycle; the pulse shows after it
        send(8'h11, 0);
        send(8'h22, 0);
        n = 0;
        while (!o_err_timeout && n < 200) begin step(); n++; end
        chk("timeout_latency", n, TMO);
        chk("timeout_idle",    o_busy, 1'b0);
        step();
        chk("timeout_once",    o_err_timeout, 1'b0);
        send_frame(24'h0A0B0C, TERM, 1);
        chk("timeout_term_as_byte0", o_frame_data, 24'h0A0B0C);

        // Strobe in the expiry cycle suppresses the timeout
        send(8'h11, 0);
        send(8'h22, TMO - 1);
        send(8'h33, 0);
        if (CK == 1) send(8'h11 ^ 8'h22 ^ 8'h33, 0);
        send(TERM, 0);
        chk("late_strobe_data", o_frame_data, 24'h112233);

        // Reset mid-frame, with a byte strobed in the reset cycle
        send(8'h77, 1);
        send(8'h88, 1);
        reset_uart = 1'b1; v = 1'b1; d = 8'h99; step();
        reset_uart = 1'b0; v = 1'b0;
        chk("midreset_data",  o_frame_data,  24'h0);
        chk("midreset_busy",  o_busy,        1'b0);
        send_frame(24'h010203, TERM, 1);
        chk("midreset_frame", o_frame_data,  24'h010203);
        chk("midreset_count", o_frame_count, 8'd1);

        // Break after one byte, then with a simultaneous strobe
        send(8'h5A, 1);
        brk = 1'b1; step(); brk = 1'b0;
        chk("break_idle",   o_busy, 1'b0);
        chk("break_noerr",  {o_err_term, o_err_timeout, o_err_chk}, 3'b000);
        send(8'h5A, 1);
        brk = 1'b1; v = 1'b1; d = TERM; step(); brk = 1'b0; v = 1'b0;
        chk("break_beats_strobe", o_busy, 1'b0);
        send_frame(24'hA1B2C3, TERM, 1);
        chk("break_next_frame", o_frame_data, 24'hA1B2C3);

`ifdef UART_FRAME_RX_CHECKSUM_EN
        send(8'h01, 1); send(8'h02, 1); send(8'h04, 1); send(8'h07, 1); send(TERM, 0);
        chk("chk_good_valid", o_frame_valid, 1'b1);
        chk("chk_good_data",  o_frame_data,  24'h010204);
        send(8'h01, 1); send(8'h02, 1); send(8'h04, 1); send(8'h06, 0);
        chk("chk_bad_pulse",  o_err_chk, 1'b1);
        chk("chk_bad_resync", o_busy,    1'b1);
        send(TERM, 0);
        chk("chk_bad_novalid", o_frame_valid, 1'b0);
        step();
        chk("chk_bad_idle",   o_busy, 1'b0);
`endif

        // Wrap: 256 back-to-back good frames with consecutive strobes
        do_reset();
        for (int k = 0; k < 255; k++) send_frame(24'($urandom), TERM, 0);
        chk("wrap_255", o_frame_count, 8'd255);
        send_frame(24'h00FF00, TERM, 0);
        chk("wrap_0",   o_frame_count, 8'd0);
        chk("wrap_data", o_frame_data, 24'h00FF00);

        // Randomized frame stream
        for (int k = 0; k < 400; k++) begin
            int gap, bp;
            if ($urandom_range(0, 99) < 3) do_reset();
            for (int i = 0; i < FB; i++) p[23-8*i -: 8] = ($urandom_range(0, 7) == 0) ? TERM : 8'($urandom);
            wb.delete();
            for (int i = 0; i < FB; i++) wb.push_back(p[23-8*i -: 8]);
            if (CK == 1) wb.push_back(p[23:16] ^ p[15:8] ^ p[7:0]);
            wb.push_back(TERM);
            if ($urandom_range(0, 7) == 0) wb[$urandom_range(0, FLEN - 1)] = 8'($urandom);
            if ($urandom_range(0, 9) == 0) wb.push_back(8'($urandom));
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 5, TMO + 5) : $urandom_range(0, 3);
            bp  = ($urandom_range(0, 39) == 0) ? $urandom_range(0, FLEN - 1) : -1;
            foreach (wb[i]) begin
                v = 1'b1; d = wb[i]; brk = (i == bp); step();
                v = 1'b0; brk = 1'b0;
                repeat (gap) step();
            end
        end

        repeat (TMO + 5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
